// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: md opcode and state encodings plus op-class helpers shared by the MDU and the D-stage hazard logic
package mdu_sequencer_pkg;
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;
    localparam int CNT_W = 4;
    function automatic logic is_multicycle(input md_op_e op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction
    function automatic logic is_div(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction
endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: E-stage issue bus into the MDU and its status/HI/LO outputs
//   master: E stage (drives start, md_op, rs_val, rt_val)
//   slave:  MDU (drives busy, md_hazard, hi, lo)
interface mdu_sequencer_if;
    import mdu_sequencer_pkg::*;
    logic        start;
    md_op_e      md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_hazard;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, md_op, rs_val, rt_val, input busy, md_hazard, hi, lo);
    modport slave  (input start, md_op, rs_val, rt_val, output busy, md_hazard, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational MDU arithmetic, maps (md_op, rs, rt, hi, lo) to the 64-bit {hi,lo} result
//   md_op_i, rs_i, rt_i, hi_i, lo_i in; res_o out = {new_hi, new_lo}
module mdu_calc
    import mdu_sequencer_pkg::*;
(
    input  md_op_e      md_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o
);
    logic        sgn;
    logic [63:0] prod;
    logic [63:0] hl;
    logic [31:0] dd;
    logic [31:0] dv;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    assign sgn = md_op_i inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
    // Low 64 bits of a product of sign-extended operands equal the signed product
    assign prod = (sgn ? {{32{rs_i[31]}}, rs_i} : {32'b0, rs_i}) * (sgn ? {{32{rt_i[31]}}, rt_i} : {32'b0, rt_i});
    assign hl = {hi_i, lo_i};
    // One unsigned divider on magnitudes; 0x80000000/-1 falls out as q=0x80000000, r=0
    assign dd = (sgn && rs_i[31]) ? -rs_i : rs_i;
    assign dv = (sgn && rt_i[31]) ? -rt_i : rt_i;
    assign uq = dd / dv;
    assign ur = dd % dv;
    assign q = (sgn && (rs_i[31] ^ rt_i[31])) ? -uq : uq;
    assign r = (sgn && rs_i[31]) ? -ur : ur;
    always_comb begin
        res_o = hl;
        case (md_op_i)
            MD_MULT, MD_MULTU: res_o = prod;
            MD_MADD, MD_MADDU: res_o = hl + prod;
            MD_MSUB, MD_MSUBU: res_o = hl - prod;
            MD_DIV, MD_DIVU:   res_o = (rt_i == '0) ? hl : {r, q};
            default:           res_o = hl;
        endcase
    end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide unit owning HI/LO, with fixed-latency busy sequencing
//   clk, reset (async, active-high); md: slave side of mdu_sequencer_if
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mdu_sequencer_if.slave md
);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      res_q, res_d, calc;
    logic             mc;
    assign mc = is_multicycle(md.md_op);
    mdu_calc u_calc (
        .md_op_i (md.md_op),
        .rs_i    (md.rs_val),
        .rt_i    (md.rt_val),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .res_o   (calc)
    );
    // Result is computed at issue and held until the counter expires; starts during RUN are dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        if (state_q == ST_RUN) begin
            cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d      = ST_IDLE;
                {hi_d, lo_d} = res_q;
            end
        end else if (md.start && mc) begin
            res_d   = calc;
            cnt_d   = is_div(md.md_op) ? DIV_LD : MUL_LD;
            state_d = ST_RUN;
        end else if (md.start && md.md_op == MD_MTHI) begin
            hi_d = md.rs_val;
        end else if (md.start && md.md_op == MD_MTLO) begin
            lo_d = md.rs_val;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end
    assign md.busy      = (state_q == ST_RUN);
    assign md.md_hazard = (md.start && mc) || md.busy;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: randomized + directed scoreboard bench for mdu_sequencer
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;
    localparam int MC = 5;
    localparam int DC = 10;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    mdu_sequencer_if md();
    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(md));
    int tests = 0;
    int fails = 0;
    logic [63:0] model = '0;
    logic [63:0] exp_q[$];
    logic flush = 1'b0;
    logic mon_pb = 1'b0;
    md_op_e ops[10] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural rules in plain integer arithmetic
    function automatic logic [63:0] ref_op(md_op_e op, logic [31:0] a, logic [31:0] b, logic [63:0] hl);
        longint sp = longint'(int'(a)) * longint'(int'(b));
        longint unsigned up = longint'(a) * longint'(b);
        int sa = a;
        int sb = b;
        case (op)
            MD_MULT:  return sp;
            MD_MULTU: return up;
            MD_MADD:  return hl + sp;
            MD_MADDU: return hl + up;
            MD_MSUB:  return hl - sp;
            MD_MSUBU: return hl - up;
            MD_DIV: begin
                if (b == 0) return hl;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            MD_DIVU:  return (b == 0) ? hl : {a % b, a / b};
            default:  return hl;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: a falling busy is the commit event; compare against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (flush) begin
                flush = 1'b0;
            end else if (mon_pb && !md.busy) begin
                if (exp_q.size() == 0) check("commit_unexpected", 64'd1, 64'd0);
                else check("commit_hilo", {md.hi, md.lo}, exp_q.pop_front());
            end
            mon_pb = md.busy;
        end
    end

    task automatic issue(md_op_e op, logic [31:0] a, logic [31:0] b, int inj = -1);
        logic mc = is_multicycle(op);
        int n = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
        int cyc = 0;
        @(negedge clk);
        md.start = 1'b1;
        md.md_op = op;
        md.rs_val = a;
        md.rt_val = b;
        #1;
        check("hazard_start", 64'(md.md_hazard), 64'(mc));
        if (mc) begin
            model = ref_op(op, a, b, model);
            exp_q.push_back(model);
        end else if (op == MD_MTHI) model[63:32] = a;
        else if (op == MD_MTLO) model[31:0] = a;
        @(negedge clk);
        md.start = 1'b0;
        md.md_op = MD_NONE;
        #1;
        if (!mc) begin
            check("busy_idle", 64'(md.busy), 64'd0);
            check("mt_hilo", {md.hi, md.lo}, model);
        end else begin
            while (md.busy && cyc < 64) begin
                check("hazard_busy", 64'(md.md_hazard), 64'd1);
                if (cyc == inj) begin
                    md.start = 1'b1;
                    md.md_op = MD_MULT;
                    md.rs_val = 32'd9;
                    md.rt_val = 32'd9;
                    $display("[TB] note: protocol violation injected, start while busy");
                end else begin
                    md.start = 1'b0;
                    md.md_op = MD_NONE;
                end
                @(negedge clk);
                #1;
                cyc++;
            end
            md.start = 1'b0;
            md.md_op = MD_NONE;
            check("busy_cycles", 64'(cyc), 64'(n));
            check("hazard_after", 64'(md.md_hazard), 64'd0);
        end
    endtask

    task automatic check_hl(string name, logic [31:0] h, logic [31:0] l);
        check(name, {md.hi, md.lo}, {h, l});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        md.start = 1'b0;
        md.md_op = MD_NONE;
        md.rs_val = '0;
        md.rt_val = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 64'(md.busy), 64'd0);
        check("rst_hazard", 64'(md.md_hazard), 64'd0);
        check_hl("rst_hilo", 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
        check_hl("mult_const", 32'hFFFFFFFF, 32'hFFFFFFFE);
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        check_hl("multu_const", 32'h00000001, 32'hFFFFFFFE);
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        check_hl("div_const", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(MD_DIVU, 32'd7, 32'd2);
        check_hl("divu_const", 32'd1, 32'd3);
        issue(MD_DIV, 32'd5, 32'd0);
        check_hl("div0_const", 32'd1, 32'd3);
        issue(MD_MTLO, 32'd5, 32'd0);
        issue(MD_MTHI, 32'd0, 32'd0);
        issue(MD_MADD, 32'd3, 32'd4);
        check_hl("madd_const", 32'd0, 32'd17);
        issue(MD_MSUB, 32'd3, 32'd6);
        check_hl("msub_const", 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(MD_MULT, 32'd2, 32'd3, 1);
        check_hl("inject_const", 32'd0, 32'd6);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        check_hl("divovf_const", 32'h0, 32'h80000000);
        issue(MD_NONE, 32'h1234, 32'h5678);
        issue(md_op_e'(4'd13), 32'h1234, 32'h5678);
        @(negedge clk);
        md.start = 1'b1;
        md.md_op = MD_MULT;
        md.rs_val = 32'd5;
        md.rt_val = 32'd7;
        @(negedge clk);
        md.start = 1'b0;
        md.md_op = MD_NONE;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        flush = 1'b1;
        #1;
        check("midrst_busy", 64'(md.busy), 64'd0);
        check("midrst_hazard", 64'(md.md_hazard), 64'd0);
        check_hl("midrst_hilo", 32'h0, 32'h0);
        exp_q.delete();
        model = '0;
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("midrst_nocommit_busy", 64'(md.busy), 64'd0);
        check_hl("midrst_nocommit_hilo", 32'h0, 32'h0);
        for (int i = 0; i < 40; i++) issue(ops[$urandom_range(0, 9)], rnd_val(), rnd_val());
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
